// File: rtl/bitstream_fetch_ctrl.sv
// Read-side controller for the MP3 bit FIFO: serves N-bit fetch and byte-align
// requests one FIFO bit per cycle, returning an MSB-first right-justified word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request; latches length and clears counters
// S_FETCH | issuing fifo_rd strobes until issued == len
// S_DRAIN | strobes done, waiting for the last in-flight bit to land
// S_RESP  | result presented on the response channel until taken
module bitstream_fetch_ctrl #(
  parameter int MAX_LEN   = 32,
  parameter int LOW_WATER = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_req_len,
  input  logic        i_req_align,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_data,
  output logic [5:0]  o_resp_len,
  output logic        o_fifo_rd,
  input  logic        i_fifo_bit,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_count,
  output logic        o_refill_req,
  output logic [2:0]  o_bit_pos
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [5:0]  MAX_LEN_W   = 6'(MAX_LEN);
  localparam logic [31:0] LOW_WATER_W = 32'(LOW_WATER);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_len;
  logic [5:0]  r_issued;
  logic [5:0]  r_captured;
  logic [31:0] r_shift;
  logic        r_align;
  logic        r_rd_d1;
  logic        r_refill;
  logic [2:0]  r_bit_pos;

  logic        w_accept;
  logic        w_rd;
  logic [5:0]  w_req_len_clamped;
  logic [5:0]  w_align_len;
  logic [5:0]  w_len_sel;
  logic [5:0]  w_issued_nxt;
  logic [5:0]  w_captured_nxt;

  assign w_accept          = (r_state == S_IDLE) && i_req_valid;
  assign w_req_len_clamped = (i_req_len > MAX_LEN_W) ? MAX_LEN_W : i_req_len;
  // (8 - bit_pos) mod 8 is just the 3-bit two's complement of bit_pos
  assign w_align_len       = {3'b000, 3'(3'd0 - r_bit_pos)};
  assign w_len_sel         = i_req_align ? w_align_len : w_req_len_clamped;

  assign w_rd = (r_state == S_FETCH) && (r_issued < r_len) && !i_fifo_empty;

  // Look-ahead counts let DRAIN/RESP be entered on the same edge as the last issue/capture
  assign w_issued_nxt   = r_issued + {5'b00000, w_rd};
  assign w_captured_nxt = r_captured + {5'b00000, r_rd_d1};

  always_comb begin
    w_state_nxt  = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_data  = '0;
    o_resp_len   = '0;
    unique case (r_state)
      S_IDLE: begin
        o_req_ready = i_rst;
        if (i_req_valid) begin
          w_state_nxt = (w_len_sel == 6'd0) ? S_RESP : S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_issued_nxt == r_len) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_captured_nxt == r_len) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_data  = r_shift;
        o_resp_len   = r_len;
        if (i_resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_rd_d1 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rd_d1 <= w_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_len      <= '0;
      r_align    <= 1'b0;
      r_issued   <= '0;
      r_captured <= '0;
      r_shift    <= '0;
    end else if (w_accept) begin
      r_len      <= w_len_sel;
      r_align    <= i_req_align;
      r_issued   <= '0;
      r_captured <= '0;
      r_shift    <= '0;
    end else begin
      r_issued   <= w_issued_nxt;
      r_captured <= w_captured_nxt;
      // Align captures go to a discard path so the returned word stays zero
      if (r_rd_d1 && !r_align) begin
        r_shift <= {r_shift[30:0], i_fifo_bit};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_bit_pos <= '0;
    end else if (r_rd_d1) begin
      r_bit_pos <= r_bit_pos + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_refill <= 1'b0;
    end else begin
      r_refill <= (i_fifo_count < LOW_WATER_W);
    end
  end

  assign o_fifo_rd    = w_rd;
  assign o_refill_req = r_refill;
  assign o_bit_pos    = r_bit_pos;

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// Directed bench for bitstream_fetch_ctrl: a queue-backed FIFO model feeds bits,
// and a scoreboard of expected responses is checked as responses are taken.
module tb_bitstream_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_len = '0;
  logic        req_align = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [5:0]  resp_len;
  logic        fifo_rd;
  logic        fifo_bit = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_count;
  logic        refill_req;
  logic [2:0]  bit_pos;

  logic        force_empty = 1'b0;
  logic        cnt_ovr_en = 1'b0;
  logic [31:0] cnt_ovr = '0;
  int          q_size = 0;

  bit fifo_q[$];
  bit ref_q[$];

  typedef struct {
    logic [31:0] data;
    logic [5:0]  len;
  } exp_t;
  exp_t sb[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int rd_pulses = 0;
  int resp_cyc  = -1;
  int n_resp    = 0;
  int model_pos = 0;

  assign fifo_empty = force_empty || (q_size == 0);
  assign fifo_count = cnt_ovr_en ? cnt_ovr : 32'(q_size);

  always #5 clk = ~clk;

  bitstream_fetch_ctrl #(.MAX_LEN(32), .LOW_WATER(64)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_len    (req_len),
    .i_req_align  (req_align),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_data  (resp_data),
    .o_resp_len   (resp_len),
    .o_fifo_rd    (fifo_rd),
    .i_fifo_bit   (fifo_bit),
    .i_fifo_empty (fifo_empty),
    .i_fifo_count (fifo_count),
    .o_refill_req (refill_req),
    .o_bit_pos    (bit_pos)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs from posedge+1 to the next posedge+1; samples DUT at the negedge in between.
  task automatic tick();
    logic rd_now;
    exp_t e;
    #4;
    rd_now = fifo_rd;
    if (fifo_rd) begin
      rd_pulses++;
      check("rd_while_empty", 64'(fifo_empty), 64'd0);
    end
    if (resp_valid && resp_cyc < 0) resp_cyc = cyc;
    if (resp_valid && resp_ready) begin
      n_resp++;
      if (sb.size() == 0) begin
        check("resp_without_request", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("resp_data", 64'(resp_data), 64'(e.data));
        check("resp_len", 64'(resp_len), 64'(e.len));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd_now && fifo_q.size() > 0) begin
      fifo_bit = fifo_q.pop_front();
      q_size   = fifo_q.size();
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      fifo_q.push_back(b[i]);
      ref_q.push_back(b[i]);
    end
    q_size = fifo_q.size();
  endtask

  task automatic do_req(input string tag, input int len, input bit align, input int hold,
                        input int stall_at, input int exp_lat, input int exp_rd);
    int   n;
    int   e_cyc;
    int   target;
    logic [31:0] d;
    exp_t e;
    bit   b;
    n = align ? ((8 - model_pos) % 8) : ((len > 32) ? 32 : len);
    d = '0;
    for (int i = 0; i < n; i++) begin
      b = ref_q.pop_front();
      if (!align) d = {d[30:0], b};
    end
    model_pos = (model_pos + n) % 8;
    e.data = d;
    e.len  = 6'(n);
    sb.push_back(e);
    target     = n_resp + 1;
    resp_cyc   = -1;
    rd_pulses  = 0;
    resp_ready = (hold == 0);
    req_len    = 6'(len);
    req_align  = align;
    req_valid  = 1'b1;
    tick();
    e_cyc     = cyc;
    req_valid = 1'b0;
    for (int k = 0; k < 200 && n_resp < target; k++) begin
      tick();
      if (stall_at > 0 && cyc - e_cyc == stall_at) force_empty = 1'b1;
      if (stall_at > 0 && cyc - e_cyc == stall_at + 4) force_empty = 1'b0;
      if (resp_cyc >= 0 && cyc - resp_cyc >= hold) resp_ready = 1'b1;
    end
    check({tag, "_done"}, 64'(n_resp), 64'(target));
    check({tag, "_lat"}, 64'(resp_cyc - e_cyc), 64'(exp_lat));
    check({tag, "_rd"}, 64'(rd_pulses), 64'(exp_rd));
    check({tag, "_bitpos"}, 64'(bit_pos), 64'(model_pos));
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    resp_ready = 1'b1;
  endtask

  initial begin
    int l;
    @(posedge clk);
    #1;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    check("rst_bit_pos", 64'(bit_pos), 64'd0);
    check("rst_refill", 64'(refill_req), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    rst = 1'b1;
    tick();
    check("rel_req_ready", 64'(req_ready), 64'd1);

    // 8-bit fetch, response held for two extra cycles before being taken
    load_byte(8'hA5);
    do_req("fetch8", 8, 1'b0, 2, 0, 9, 8);

    // 3-bit fetch, byte align, then 8-bit fetch
    load_byte(8'hE0);
    load_byte(8'h55);
    do_req("fetch3", 3, 1'b0, 0, 0, 4, 3);
    check("fetch3_pos3", 64'(bit_pos), 64'd3);
    do_req("align5", 0, 1'b1, 0, 0, 6, 5);
    do_req("fetch8b", 8, 1'b0, 0, 0, 9, 8);

    // Align on a byte boundary completes immediately
    do_req("align0", 0, 1'b1, 0, 0, 0, 0);

    // 12-bit fetch with four empty cycles injected
    load_byte(8'h3C);
    load_byte(8'h9B);
    do_req("stall12", 12, 1'b0, 0, 3, 17, 12);
    do_req("fetch4", 4, 1'b0, 0, 0, 5, 4);

    // Oversized request clamps to 32, then 1-bit and 7-bit fetches
    load_byte(8'hDE);
    load_byte(8'hAD);
    load_byte(8'hBE);
    load_byte(8'hEF);
    load_byte(8'h01);
    do_req("clamp40", 40, 1'b0, 0, 0, 33, 32);
    do_req("fetch1", 1, 1'b0, 0, 0, 2, 1);
    do_req("fetch7", 7, 1'b0, 0, 0, 8, 7);

    for (int i = 0; i < 32; i++) load_byte(8'($urandom_range(0, 255)));
    for (int i = 0; i < 6; i++) begin
      l = int'($urandom_range(1, 32));
      do_req("rnd", l, 1'b0, 0, 0, l + 1, l);
    end

    // Reset in the middle of a fetch
    load_byte(8'hC3);
    load_byte(8'h5A);
    req_len   = 6'd16;
    req_align = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    check("mid_fetch_rd", 64'(fifo_rd), 64'd1);
    rst = 1'b0;
    tick();
    check("midrst_fifo_rd", 64'(fifo_rd), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_bit_pos", 64'(bit_pos), 64'd0);
    check("midrst_refill", 64'(refill_req), 64'd0);
    fifo_q.delete();
    ref_q.delete();
    q_size    = 0;
    model_pos = 0;
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_bit_pos", 64'(bit_pos), 64'd0);
    load_byte(8'h96);
    do_req("post_rst_fetch", 8, 1'b0, 0, 0, 9, 8);

    // Low-water threshold and one-cycle lag
    cnt_ovr_en = 1'b1;
    cnt_ovr    = 32'd63;
    tick();
    check("refill_63", 64'(refill_req), 64'd1);
    cnt_ovr = 32'd64;
    check("refill_lag", 64'(refill_req), 64'd1);
    tick();
    check("refill_64", 64'(refill_req), 64'd0);
    cnt_ovr = 32'd63;
    tick();
    check("refill_63b", 64'(refill_req), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitstream_fetch_ctrl.md
# bitstream_fetch_ctrl

Read-side controller for the byte-in/bit-out stream FIFO in the MP3 decode path. It accepts "give me N bits" requests (1–32) or "byte-align" requests from header/side-info/Huffman parsers. It drives the FIFO's one-bit-per-cycle read strobe and assembles the bits MSB-first into a right-justified word. It returns the word on a valid/ready response channel, and flags the upstream byte loader when FIFO occupancy runs low.

## Interface
- MAX_LEN, 32: maximum bits per request; req_len above this is clamped.
- LOW_WATER, 64: refill_req asserts while fifo_count < LOW_WATER (bits).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on clk edge).
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request (high only in IDLE).
- req_len  in  6  bits requested; ignored when req_align=1.
- req_align  in  1  discard bits up to next byte boundary.
- resp_valid  out  1  result available; held until resp_ready.
- resp_ready  in  1  consumer takes result.
- resp_data  out  32  fetched bits, right-justified, first-read bit most significant; 0 for align.
- resp_len  out  6  bits fetched or discarded.
- fifo_rd  out  1  read strobe to FIFO (one bit per asserted cycle).
- fifo_bit  in  1  FIFO data_out, valid the cycle after fifo_rd.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  32  FIFO data_count (bits held).
- refill_req  out  1  registered, fifo_count < LOW_WATER.
- bit_pos  out  3  total bits consumed mod 8.

## Operation
- States: IDLE, FETCH, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the target length: len = min(req_len, MAX_LEN) for a fetch; len = (8 − bit_pos) mod 8 for an align.
  - Clear shift register and counters.
  - If len==0, go to RESP with resp_len=0, resp_data=0. Otherwise go to FETCH.
- FETCH:
  - fifo_rd = (issued < len) && !fifo_empty; issued increments on each fifo_rd.
  - Registered rd_d1 = fifo_rd.
  - When rd_d1=1, capture: shift <= {shift[30:0], fifo_bit}, and captured and bit_pos increment.
  - Align requests capture into a discard path; shift stays 0.
  - When issued reaches len, go to DRAIN.
- DRAIN:
  - fifo_rd=0.
  - Wait for the final capture (captured==len), then go to RESP.
- RESP:
  - resp_valid=1; resp_data=shift; resp_len=len.
  - On resp_ready, go to IDLE.
- fifo_empty stalls issue only. Captures of already-issued bits still complete.
- Never assert fifo_rd when fifo_empty=1 or outside FETCH.
- Counters are 6-bit and never exceed len. bit_pos wraps 7→0.
- refill_req is independent of state and updates every cycle.

## Timing
- Reset values: req_ready=0 during reset (1 the cycle after release); all other outputs 0; bit_pos=0; state IDLE.
- Request handshake at edge E:
  - fifo_rd high in cycles E+1 … E+N when the FIFO stays non-empty.
  - Last capture at edge E+N+1.
  - resp_valid high from cycle E+N+2.
- Each cycle of fifo_empty during FETCH adds exactly one cycle of latency.
- Request handshake to response for len=0: resp_valid one cycle after the handshake.
- resp_ready taken in the same cycle resp_valid rises returns to IDLE next cycle. A new request is accepted the cycle after.
- Reset mid-operation: the state machine returns to IDLE, and fifo_rd drops on the reset edge. A bit in flight is discarded and bit_pos is cleared. FIFO reset is owned elsewhere.
- refill_req lags fifo_count by one cycle.

## Test plan
- Fetch 8 bits from FIFO loaded with 0xA5:
  - fifo_rd high 8 consecutive cycles.
  - resp_data=0x000000A5, resp_len=8, resp_valid at E+10.
  - bit_pos=0 afterwards.
- Fetch 3 bits then align from 0xE0,0x55:
  - First response resp_data=0x7, bit_pos=3.
  - Align discards 5 bits, resp_len=5, resp_data=0.
  - A following fetch of 8 returns 0x55.
- Align with bit_pos=0: immediate response resp_len=0, no fifo_rd pulses.
- Fetch 12 with fifo_empty forced high for 4 cycles mid-fetch:
  - No fifo_rd while empty.
  - Response 4 cycles later than the unstalled case, with the correct 12-bit value.
- req_len=40: clamped to 32; 32 rd pulses; resp_len=32.
- Assert rst=0 mid-FETCH:
  - fifo_rd=0 next cycle; outputs return to reset values.
  - After release, req_ready=1 and bit_pos=0.
- Also check: refill_req=1 when fifo_count=63, and 0 when fifo_count=64.
